// File: rtl/endpoint_arb_pkg.sv
// Shared types and constants for the endpoint lookup arbiter.
//   state_e  : arbiter FSM states (idle, issue to engine, wait for result, respond)
//   id_width : width of the requester index for a given requester count
//   IP_W / MAC_W : address widths used on the request, lookup and response channels
package endpoint_arb_pkg;

   localparam int unsigned IP_W  = 32;
   localparam int unsigned MAC_W = 48;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   // Requester index width; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/endpoint_lookup_arbiter_if.sv
// Bundle of the requester, response and lookup-engine handshakes around the arbiter.
//   master : the arbiter side (accepts requests, drives the engine, returns responses)
//   slave  : the environment side (requesters, response consumer, lookup engine)
//   req_*    : per-requester valid/ready and packed destination IPs
//   rsp_*    : shared response channel tagged with the requester index
//   lookup_* : valid/ready request plus done-pulse result from the lookup engine
interface endpoint_lookup_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   import endpoint_arb_pkg::*;

   localparam int unsigned ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [IP_W*NUM_REQ-1:0] req_dst_ip;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic                    rsp_hit;
   logic                    rsp_error;
   logic                    rsp_timeout;
   logic [MAC_W-1:0]        rsp_dst_mac;
   logic [MAC_W-1:0]        rsp_src_mac;

   logic                    lookup_valid;
   logic                    lookup_ready;
   logic [IP_W-1:0]         lookup_dst_ip;
   logic                    lookup_done;
   logic                    lookup_hit;
   logic                    lookup_error;
   logic [MAC_W-1:0]        lookup_dst_mac;
   logic [MAC_W-1:0]        lookup_src_mac;

   modport master (
      input  req_valid, req_dst_ip, rsp_ready,
      input  lookup_ready, lookup_done, lookup_hit, lookup_error,
      input  lookup_dst_mac, lookup_src_mac,
      output req_ready, rsp_valid, rsp_id, rsp_hit, rsp_error, rsp_timeout,
      output rsp_dst_mac, rsp_src_mac, lookup_valid, lookup_dst_ip
   );

   modport slave (
      output req_valid, req_dst_ip, rsp_ready,
      output lookup_ready, lookup_done, lookup_hit, lookup_error,
      output lookup_dst_mac, lookup_src_mac,
      input  req_ready, rsp_valid, rsp_id, rsp_hit, rsp_error, rsp_timeout,
      input  rsp_dst_mac, rsp_src_mac, lookup_valid, lookup_dst_ip
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, searching
// cyclically.
//   req   : request bits
//   ptr   : search start index (must be < NUM_REQ)
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted request
//   any   : at least one request present
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      logic [ID_W-1:0] cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(ptr) + k) % NUM_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/endpoint_lookup_arbiter.sv
// Shares one endpoint lookup engine between NUM_REQ requesters with round-robin fairness.
// One lookup is outstanding at a time; each result goes out on the shared response
// channel tagged with the requester index.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : master side of endpoint_lookup_arbiter_if (request/response/lookup channels)
// Optional feature: define LOOKUP_TIMEOUT_EN to abort lookups that stay in WAIT for
// TIMEOUT_CYCLES cycles; the response then reports timeout+error with zero MACs.
module endpoint_lookup_arbiter
   import endpoint_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                        clk,
   input logic                        rst,
   endpoint_lookup_arbiter_if.master  bus
);

   localparam int unsigned     ID_W    = id_width(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   state_e             state_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    id_q;
   logic               lookup_valid_q;
   logic [IP_W-1:0]    lookup_ip_q;
   logic               rsp_valid_q;
   logic               rsp_hit_q;
   logic               rsp_error_q;
   logic [MAC_W-1:0]   rsp_dst_mac_q;
   logic [MAC_W-1:0]   rsp_src_mac_q;

`ifdef LOOKUP_TIMEOUT_EN
   localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic               rsp_timeout_q;
   logic [TMO_W-1:0]   tmo_cnt_q;
`endif

   logic [NUM_REQ-1:0] grant_oh;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   logic [IP_W-1:0]    req_ip [NUM_REQ];
   logic               mac_ok;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_ip[g] = bus.req_dst_ip[g*IP_W +: IP_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant_oh),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   // Only a clean hit carries MACs through; misses and errors report zero.
   assign mac_ok = bus.lookup_hit && !bus.lookup_error;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         rr_ptr_q       <= '0;
         id_q           <= '0;
         lookup_valid_q <= 1'b0;
         lookup_ip_q    <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_hit_q      <= 1'b0;
         rsp_error_q    <= 1'b0;
         rsp_dst_mac_q  <= '0;
         rsp_src_mac_q  <= '0;
`ifdef LOOKUP_TIMEOUT_EN
         rsp_timeout_q  <= 1'b0;
         tmo_cnt_q      <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  id_q           <= grant_idx;
                  lookup_ip_q    <= req_ip[grant_idx];
                  lookup_valid_q <= 1'b1;
                  state_q        <= StIssue;
               end
            end
            StIssue: begin
               if (bus.lookup_ready) begin
                  lookup_valid_q <= 1'b0;
                  state_q        <= StWait;
`ifdef LOOKUP_TIMEOUT_EN
                  tmo_cnt_q      <= '0;
`endif
               end
            end
            StWait: begin
               // A completion in the final timeout cycle still wins over the abort.
               if (bus.lookup_done) begin
                  rsp_hit_q     <= bus.lookup_hit;
                  rsp_error_q   <= bus.lookup_error;
                  rsp_dst_mac_q <= mac_ok ? bus.lookup_dst_mac : '0;
                  rsp_src_mac_q <= mac_ok ? bus.lookup_src_mac : '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= StResp;
`ifdef LOOKUP_TIMEOUT_EN
                  rsp_timeout_q <= 1'b0;
`endif
               end
`ifdef LOOKUP_TIMEOUT_EN
               else if (tmo_cnt_q == TMO_LAST) begin
                  rsp_hit_q     <= 1'b0;
                  rsp_error_q   <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_dst_mac_q <= '0;
                  rsp_src_mac_q <= '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= StResp;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Grant is combinational so a requester sees its accept in the cycle it is chosen.
   assign bus.req_ready     = (state_q == StIdle && !rst) ? grant_oh : '0;
   assign bus.lookup_valid  = lookup_valid_q;
   assign bus.lookup_dst_ip = lookup_ip_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_id        = id_q;
   assign bus.rsp_hit       = rsp_hit_q;
   assign bus.rsp_error     = rsp_error_q;
   assign bus.rsp_dst_mac   = rsp_dst_mac_q;
   assign bus.rsp_src_mac   = rsp_src_mac_q;
`ifdef LOOKUP_TIMEOUT_EN
   assign bus.rsp_timeout   = rsp_timeout_q;
`else
   assign bus.rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_endpoint_lookup_arbiter.sv
// Self-checking bench for endpoint_lookup_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction-level
// model. Build with LOOKUP_TIMEOUT_EN to exercise the timeout abort as well.
module tb_endpoint_lookup_arbiter;
   import endpoint_arb_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned TC = 16;
`ifdef LOOKUP_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   endpoint_lookup_arbiter_if #(.NUM_REQ(N)) bus ();

   endpoint_lookup_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One current transaction record; phases: granted -> issued -> resolved -> handed off.
   bit          m_txn = 0, m_issued = 0, m_resolved = 0;
   int          m_id = 0, m_ptr = 0, m_wait = 0;
   logic [31:0] m_ip = '0;
   logic        m_hit = 0, m_err = 0, m_tmo = 0;
   logic [47:0] m_dmac = '0, m_smac = '0;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (ptr + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_txn = 0; m_ptr = 0; m_id = 0; m_ip = '0;
         m_hit = 0; m_err = 0; m_tmo = 0; m_dmac = '0; m_smac = '0;
      end else if (!m_txn) begin
         int g;
         g = pick(bus.req_valid, m_ptr);
         if (g >= 0) begin
            m_txn = 1; m_id = g; m_ip = bus.req_dst_ip[32*g +: 32];
            m_issued = 0; m_resolved = 0;
         end
      end else if (!m_issued) begin
         if (bus.lookup_ready) begin m_issued = 1; m_wait = 0; end
      end else if (!m_resolved) begin
         if (bus.lookup_done) begin
            m_resolved = 1; m_hit = bus.lookup_hit; m_err = bus.lookup_error; m_tmo = 0;
            m_dmac = (m_hit && !m_err) ? bus.lookup_dst_mac : 48'h0;
            m_smac = (m_hit && !m_err) ? bus.lookup_src_mac : 48'h0;
         end else if (TMO_EN && m_wait == TC - 1) begin
            m_resolved = 1; m_hit = 0; m_err = 1; m_tmo = 1; m_dmac = '0; m_smac = '0;
         end else begin
            m_wait++;
         end
      end else if (bus.rsp_ready) begin
         m_txn = 0;
         m_ptr = (m_id + 1) % N;
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      logic [N-1:0] er;
      int g;
      if (rst) begin
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_lookup_valid", bus.lookup_valid, 0);
         check("rst_lookup_ip", bus.lookup_dst_ip, 0);
         check("rst_rsp_valid", bus.rsp_valid, 0);
         check("rst_rsp_id", bus.rsp_id, 0);
         check("rst_rsp_flags", {bus.rsp_hit, bus.rsp_error, bus.rsp_timeout}, 0);
         check("rst_rsp_macs", {bus.rsp_dst_mac, bus.rsp_src_mac} == 96'h0, 1);
      end else begin
         er = '0;
         if (!m_txn) begin
            g = pick(bus.req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
         end
         check("mdl_req_ready", bus.req_ready, er);
         check("mdl_lookup_valid", bus.lookup_valid, m_txn && !m_issued);
         if (m_txn && !m_issued) check("mdl_lookup_ip", bus.lookup_dst_ip, m_ip);
         check("mdl_rsp_valid", bus.rsp_valid, m_txn && m_resolved);
         if (m_txn && m_resolved) begin
            check("mdl_rsp_id", bus.rsp_id, m_id);
            check("mdl_rsp_flags", {bus.rsp_hit, bus.rsp_error, bus.rsp_timeout},
                  {m_hit, m_err, m_tmo});
            check("mdl_rsp_dmac", bus.rsp_dst_mac, m_dmac);
            check("mdl_rsp_smac", bus.rsp_src_mac, m_smac);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ip(input int i, input logic [31:0] ip);
      bus.req_dst_ip[32*i +: 32] = ip;
   endtask

   // Drives one lookup to completion; entered the cycle after the request was accepted.
   task automatic serve_one(input int exp_id, input logic [31:0] exp_ip, input logic hit,
                            input logic err, input logic [47:0] dm, input logic [47:0] sm,
                            input int stall_issue, input int stall_rsp);
      logic [47:0] edm, esm;
      edm = (hit && !err) ? dm : 48'h0;
      esm = (hit && !err) ? sm : 48'h0;
      bus.lookup_ready = 1'b0;
      for (int s = 0; s < stall_issue; s++) begin
         @(negedge clk);
         check("stall_lookup_valid", bus.lookup_valid, 1);
         check("stall_lookup_ip", bus.lookup_dst_ip, exp_ip);
         check("stall_issue_req_ready", bus.req_ready, 0);
         tick();
      end
      bus.lookup_ready = 1'b1;
      @(negedge clk);
      check("issue_lookup_ip", bus.lookup_dst_ip, exp_ip);
      tick();
      bus.lookup_ready   = 1'b0;
      bus.lookup_done    = 1'b1;
      bus.lookup_hit     = hit;
      bus.lookup_error   = err;
      bus.lookup_dst_mac = dm;
      bus.lookup_src_mac = sm;
      @(negedge clk);
      check("done_cycle_rsp_valid", bus.rsp_valid, 0);
      tick();
      bus.lookup_done = 1'b0;
      @(negedge clk);
      check("rsp_valid_after_done", bus.rsp_valid, 1);
      check("rsp_id", bus.rsp_id, exp_id);
      check("rsp_hit_err", {bus.rsp_hit, bus.rsp_error}, {hit, err});
      check("rsp_dst_mac", bus.rsp_dst_mac, edm);
      check("rsp_src_mac", bus.rsp_src_mac, esm);
      bus.rsp_ready = 1'b0;
      for (int s = 0; s < stall_rsp; s++) begin
         tick();
         @(negedge clk);
         check("stall_rsp_valid", bus.rsp_valid, 1);
         check("stall_rsp_id", bus.rsp_id, exp_id);
         check("stall_rsp_dmac", bus.rsp_dst_mac, edm);
         check("stall_rsp_req_ready", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   logic [31:0] ip_tab [N];
   int          order [5] = '{0, 1, 2, 3, 0};

   initial begin
      logic [N-1:0] pending, acc;
      logic [N-1:0] exp_oh;

      bus.req_valid = '0; bus.req_dst_ip = '0; bus.rsp_ready = 1'b0;
      bus.lookup_ready = 1'b0; bus.lookup_done = 1'b0; bus.lookup_hit = 1'b0;
      bus.lookup_error = 1'b0; bus.lookup_dst_mac = '0; bus.lookup_src_mac = '0;
      for (int i = 0; i < N; i++) ip_tab[i] = 32'h0A00_0010 + i;

      // Reset.
      #2 rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // All four requesting continuously: grants 0,1,2,3,0.
      bus.req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_ip(i, ip_tab[i]);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_oh = '0;
         exp_oh[order[k]] = 1'b1;
         check("rr_order_grant", bus.req_ready, exp_oh);
         tick();
         serve_one(order[k], ip_tab[order[k]], 1'b1, 1'b0, {16'hD00D, ip_tab[order[k]]},
                   {16'h5A5A, ip_tab[order[k]]}, 0, 0);
      end
      bus.req_valid = '0;

      // Single request from requester 2.
      set_ip(2, 32'hC0A8_010A);
      bus.req_valid = 4'b0100;
      @(negedge clk);
      check("single_req_ready", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      check("single_lookup_valid", bus.lookup_valid, 1);
      serve_one(2, 32'hC0A8_010A, 1'b1, 1'b0, 48'h1122_3344_5566, 48'hAABB_CCDD_EEFF, 0, 0);

      // Miss from requester 1.
      set_ip(1, 32'h0A00_0001);
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = '0;
      serve_one(1, 32'h0A00_0001, 1'b0, 1'b0, 48'hDEAD_BEEF_0001, 48'h0BAD_F00D_0002, 0, 0);

      // Back-pressure with everyone else requesting: pointer is at 2.
      bus.req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_ip(i, ip_tab[i]);
      @(negedge clk);
      check("bp_grant", bus.req_ready, 4'b0100);
      tick();
      serve_one(2, ip_tab[2], 1'b1, 1'b1, 48'h1234_5678_9ABC, 48'h0000_1111_2222, 20, 10);
      bus.req_valid = '0;

`ifdef LOOKUP_TIMEOUT_EN
      // Lookup never completes: abort after TC cycles in WAIT.
      set_ip(0, 32'h0A0A_0A0A);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      check("tmo_grant", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      bus.lookup_ready = 1'b1;
      tick();
      bus.lookup_ready = 1'b0;
      for (int k = 0; k < TC; k++) begin
         @(negedge clk);
         check("tmo_wait_rsp_valid", bus.rsp_valid, 0);
         tick();
      end
      @(negedge clk);
      check("tmo_rsp_valid", bus.rsp_valid, 1);
      check("tmo_flags", {bus.rsp_hit, bus.rsp_error, bus.rsp_timeout}, 3'b011);
      check("tmo_macs", {bus.rsp_dst_mac, bus.rsp_src_mac} == 96'h0, 1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
`endif

      // Stale completion while idle must not produce a response.
      bus.lookup_done = 1'b1;
      bus.lookup_hit  = 1'b1;
      tick();
      bus.lookup_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("late_done_rsp_valid", bus.rsp_valid, 0);
         tick();
      end

      // Reset while in WAIT; afterwards requester 0 wins from a cleared pointer.
      set_ip(3, 32'hAC10_0003);
      bus.req_valid = 4'b1000;
      @(negedge clk);
      check("rw_grant", bus.req_ready, 4'b1000);
      tick();
      bus.req_valid = 4'b1111;
      bus.lookup_ready = 1'b1;
      tick();
      bus.lookup_ready = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rw_lookup_valid", bus.lookup_valid, 0);
      check("rw_rsp_valid", bus.rsp_valid, 0);
      check("rw_req_ready", bus.req_ready, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rw_post_grant", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      serve_one(0, ip_tab[0], 1'b1, 1'b0, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 2, 1);

      // Randomized traffic; the model checks every cycle.
      pending = '0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         acc = bus.req_ready;
         tick();
         pending &= ~acc;
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && $urandom_range(3) == 0) begin
               pending[i] = 1'b1;
               set_ip(i, $urandom);
            end
         end
         bus.req_valid      = pending;
         bus.lookup_ready   = 1'($urandom_range(1));
         bus.lookup_done    = ($urandom_range(3) == 0);
         bus.lookup_hit     = 1'($urandom_range(1));
         bus.lookup_error   = ($urandom_range(4) == 0);
         bus.lookup_dst_mac = {16'($urandom), $urandom};
         bus.lookup_src_mac = {16'($urandom), $urandom};
         bus.rsp_ready      = 1'($urandom_range(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
